// File: rtl/post_spi_link_if.sv
`default_nettype none
// ============================================================================
// Module   : post_spi_link_if
// Brief    : Byte-buffer handshake between the SPI link and the POST buffers.
// Revision : 1.0 - initial release
// ============================================================================
interface post_spi_link_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_full;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  tx_full;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  rx_ack;

    // master = SPI link side, slave = buffer side
    modport master (
        input  rx_full, rx_data, tx_full,
        output tx_load, tx_data, rx_ack
    );

    modport slave (
        output rx_full, rx_data, tx_full,
        input  tx_load, tx_data, rx_ack
    );
endinterface
`default_nettype wire

// File: rtl/post_spi_link.sv
`default_nettype none
// ============================================================================
// Module   : post_spi_link
// Brief    : Oversampled SPI mode-0 slave exchanging flags + one byte per frame
//            between the board MCU and the POST box byte buffers.
// Revision : 1.0 - initial release
// ============================================================================
module post_spi_link #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 8
) (
    input  wire logic        fpga_clock_48mhz,
    input  wire logic        reset_n,
    input  wire logic        fpga_spi_cs,
    input  wire logic        fpga_spi_sck,
    input  wire logic        fpga_spi_mosi,
    output logic             fpga_spi_miso,
    output logic             spi_busy,
    post_spi_link_if.master  buf_if
);

    localparam int c_FRAME_BITS = 2 * DATA_WIDTH;
    localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_FRAME_BITS);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    logic [SYNC_STAGES-1:0]  r_cs_sync;
    logic [SYNC_STAGES-1:0]  r_sck_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic                    r_cs_prev;
    logic                    r_sck_prev;
    logic [1:0]              r_state;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [c_FRAME_BITS-1:0] r_miso_sr;
    logic [c_FRAME_BITS-1:0] r_mosi_sr;
    logic                    r_rx_full_s;
    logic                    r_tx_full_s;
    logic                    r_start_pend;

    logic                    w_cs;
    logic                    w_sck;
    logic                    w_mosi;
    logic                    w_cs_fall;
    logic                    w_cs_rise;
    logic                    w_sck_rise;
    logic                    w_sck_fall;
    logic                    w_mcu_has_byte;
    logic                    w_mcu_has_space;
    logic                    w_do_load;
    logic [c_FRAME_BITS-1:0] w_miso_load;
    logic                    w_unused_flags;

    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_cs_fall  = r_cs_prev & ~w_cs;
    assign w_cs_rise  = ~r_cs_prev & w_cs;
    assign w_sck_rise = ~r_sck_prev & w_sck;
    assign w_sck_fall = r_sck_prev & ~w_sck;

    assign w_mcu_has_byte  = r_mosi_sr[DATA_WIDTH+1];
    assign w_mcu_has_space = r_mosi_sr[DATA_WIDTH];
    assign w_do_load       = w_mcu_has_byte & ~r_tx_full_s;
    assign w_unused_flags  = ^r_mosi_sr[c_FRAME_BITS-1:DATA_WIDTH+2];

    // Flags byte, then the rx byte only when there is one to report
    assign w_miso_load = {{(DATA_WIDTH-2){1'b0}}, buf_if.rx_full, ~buf_if.tx_full,
                          (buf_if.rx_full ? buf_if.rx_data : {DATA_WIDTH{1'b0}})};

    assign spi_busy = ~w_cs;

    always_ff @(posedge fpga_clock_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_sync      <= {SYNC_STAGES{1'b1}};
            r_sck_sync     <= '0;
            r_mosi_sync    <= '0;
            r_cs_prev      <= 1'b1;
            r_sck_prev     <= 1'b0;
            r_state        <= c_ST_IDLE;
            r_bit_cnt      <= '0;
            r_miso_sr      <= '0;
            r_mosi_sr      <= '0;
            r_rx_full_s    <= 1'b0;
            r_tx_full_s    <= 1'b0;
            r_start_pend   <= 1'b0;
            fpga_spi_miso  <= 1'b0;
            buf_if.tx_load <= 1'b0;
            buf_if.tx_data <= '0;
            buf_if.rx_ack  <= 1'b0;
        end else begin
            r_cs_sync      <= {r_cs_sync[SYNC_STAGES-2:0], fpga_spi_cs};
            r_sck_sync     <= {r_sck_sync[SYNC_STAGES-2:0], fpga_spi_sck};
            r_mosi_sync    <= {r_mosi_sync[SYNC_STAGES-2:0], fpga_spi_mosi};
            r_cs_prev      <= w_cs;
            r_sck_prev     <= w_sck;
            buf_if.tx_load <= 1'b0;
            buf_if.rx_ack  <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_cs_fall || r_start_pend) begin
                        r_start_pend  <= 1'b0;
                        r_rx_full_s   <= buf_if.rx_full;
                        r_tx_full_s   <= buf_if.tx_full;
                        r_miso_sr     <= w_miso_load;
                        fpga_spi_miso <= w_miso_load[c_FRAME_BITS-1];
                        r_bit_cnt     <= '0;
                        r_state       <= c_ST_SHIFT;
                    end
                end

                c_ST_SHIFT: begin
                    if (w_cs_rise) begin
                        if (r_bit_cnt == c_CNT_FULL) begin
                            // Pulses are issued here so they coincide with COMMIT
                            buf_if.tx_load <= w_do_load;
                            buf_if.rx_ack  <= w_mcu_has_space & r_rx_full_s;
                            if (w_do_load) begin
                                buf_if.tx_data <= r_mosi_sr[DATA_WIDTH-1:0];
                            end
                            r_state <= c_ST_COMMIT;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        if (w_sck_rise && (r_bit_cnt != c_CNT_FULL)) begin
                            r_mosi_sr <= {r_mosi_sr[c_FRAME_BITS-2:0], w_mosi};
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end
                        if (w_sck_fall) begin
                            r_miso_sr     <= {r_miso_sr[c_FRAME_BITS-2:0], 1'b0};
                            fpga_spi_miso <= r_miso_sr[c_FRAME_BITS-2];
                        end
                    end
                end

                c_ST_COMMIT: begin
                    // A CS fall here would otherwise be lost; replay it from IDLE
                    if (w_cs_fall) begin
                        r_start_pend <= 1'b1;
                    end
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_post_spi_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_post_spi_link
// Brief    : Scoreboard bench for post_spi_link: MISO words and commit pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_post_spi_link;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic spi_cs  = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic spi_busy;

    int tests = 0;
    int fails = 0;
    int flip_at = -1;
    logic [7:0] flip_data = 8'h00;

    logic [15:0] exp_miso[$];
    logic [9:0]  exp_pulse[$];   // {tx_load, rx_ack, tx_data-if-loaded}

    int          mon_bits = 0;
    logic [15:0] mon_word = '0;

    post_spi_link_if #(.DATA_WIDTH(8)) bif();

    post_spi_link #(.SYNC_STAGES(2), .DATA_WIDTH(8)) dut (
        .fpga_clock_48mhz (clk),
        .reset_n          (reset_n),
        .fpga_spi_cs      (spi_cs),
        .fpga_spi_sck     (spi_sck),
        .fpga_spi_mosi    (spi_mosi),
        .fpga_spi_miso    (spi_miso),
        .spi_busy         (spi_busy),
        .buf_if           (bif)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // MISO monitor: MCU samples on SCK rise; compare when CS rises after >=16 bits
    always @(posedge spi_sck or posedge spi_cs) begin
        if (spi_cs) begin
            if (mon_bits >= 16) begin
                if (exp_miso.size() == 0) check("miso_unexpected", {16'h0, mon_word}, 32'hFFFF_FFFF);
                else check("miso_word", {16'h0, mon_word}, {16'h0, exp_miso.pop_front()});
            end
            mon_bits = 0;
        end else begin
            if (mon_bits < 16) mon_word = {mon_word[14:0], spi_miso};
            mon_bits++;
        end
    end

    // Commit pulse monitor
    always @(negedge clk) begin
        if (bif.tx_load === 1'b1 || bif.rx_ack === 1'b1) begin
            if (exp_pulse.size() == 0)
                check("pulse_unexpected", {22'h0, bif.tx_load, bif.rx_ack, bif.tx_data}, 32'h0);
            else
                check("commit_pulse", {22'h0, bif.tx_load, bif.rx_ack, (bif.tx_load ? bif.tx_data : 8'h00)},
                      {22'h0, exp_pulse.pop_front()});
        end
    end

    task automatic spi_frame(input logic [15:0] w, input int nbits, input bit keep_cs);
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_in_frame", {31'h0, spi_busy}, 32'h1);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 16) ? w[15-i] : 1'b1;
            if (i == flip_at) begin
                bif.rx_full = 1'b1;
                bif.rx_data = flip_data;
            end
            repeat (5) @(negedge clk);
            spi_sck = 1'b1;
            repeat (5) @(negedge clk);
            spi_sck = 1'b0;
        end
        if (!keep_cs) begin
            repeat (6) @(negedge clk);
            spi_cs = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.rx_full = 1'b0;
        bif.rx_data = 8'h00;
        bif.tx_full = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso",    {31'h0, spi_miso},     32'h0);
        check("rst_tx_load", {31'h0, bif.tx_load},  32'h0);
        check("rst_tx_data", {24'h0, bif.tx_data},  32'h0);
        check("rst_rx_ack",  {31'h0, bif.rx_ack},   32'h0);
        check("rst_busy",    {31'h0, spi_busy},     32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Idle frame
        exp_miso.push_back(16'h0100);
        spi_frame(16'h0100, 16, 1'b0);

        // Null poll, twice
        bif.rx_full = 1'b1; bif.rx_data = 8'hA8;
        exp_miso.push_back(16'h03A8);
        spi_frame(16'h0000, 16, 1'b0);
        exp_miso.push_back(16'h03A8);
        spi_frame(16'h0000, 16, 1'b0);

        // Read, then write, then write refused
        exp_miso.push_back(16'h03A8);
        exp_pulse.push_back({1'b0, 1'b1, 8'h00});
        spi_frame(16'h0100, 16, 1'b0);
        bif.rx_full = 1'b0;
        exp_miso.push_back(16'h0100);
        exp_pulse.push_back({1'b1, 1'b0, 8'h73});
        spi_frame(16'h0373, 16, 1'b0);
        bif.tx_full = 1'b1;
        exp_miso.push_back(16'h0000);
        spi_frame(16'h03E6, 16, 1'b0);
        check("tx_data_hold", {24'h0, bif.tx_data}, 32'h73);
        bif.tx_full = 1'b0;

        // Simultaneous commit
        bif.rx_full = 1'b1; bif.rx_data = 8'h42;
        exp_miso.push_back(16'h0342);
        exp_pulse.push_back({1'b1, 1'b1, 8'h12});
        spi_frame(16'h0312, 16, 1'b0);

        // Aborted after 11 bits, then a normal frame
        spi_frame(16'h0355, 11, 1'b0);
        exp_miso.push_back(16'h0342);
        exp_pulse.push_back({1'b1, 1'b1, 8'h55});
        spi_frame(16'h0355, 16, 1'b0);

        // Reset at bit 9
        spi_frame(16'h0377, 9, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_miso",    {31'h0, spi_miso},    32'h0);
        check("mid_rst_tx_load", {31'h0, bif.tx_load}, 32'h0);
        check("mid_rst_tx_data", {24'h0, bif.tx_data}, 32'h0);
        check("mid_rst_rx_ack",  {31'h0, bif.rx_ack},  32'h0);
        check("mid_rst_busy",    {31'h0, spi_busy},    32'h0);
        repeat (3) @(negedge clk);
        spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_miso.push_back(16'h0342);
        exp_pulse.push_back({1'b1, 1'b1, 8'h99});
        spi_frame(16'h0399, 16, 1'b0);

        // rx_full rises mid-frame: reported next frame only
        bif.rx_full = 1'b0;
        flip_at = 4; flip_data = 8'h5A;
        exp_miso.push_back(16'h0100);
        spi_frame(16'h0101, 16, 1'b0);
        flip_at = -1;
        exp_miso.push_back(16'h035A);
        exp_pulse.push_back({1'b0, 1'b1, 8'h00});
        spi_frame(16'h0100, 16, 1'b0);

        // Extra SCK pulses beyond 16 are ignored
        bif.rx_full = 1'b0;
        exp_miso.push_back(16'h0100);
        exp_pulse.push_back({1'b1, 1'b0, 8'hC3});
        spi_frame(16'h02C3, 18, 1'b0);

        repeat (20) @(negedge clk);
        check("miso_queue_drained",  exp_miso.size(),  32'h0);
        check("pulse_queue_drained", exp_pulse.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/post_spi_link.md
Name: post_spi_link

Overview:
- SPI slave transaction engine between the board MCU and the POST box byte buffers.
- Each chip-select frame is 16 bits and exchanges availability flags plus one data byte in each direction.
- It hands the MCU's byte to the target-bound tx buffer and pops the target-sent rx buffer.
- All SPI pins are sampled in the 48 MHz domain; no SCK-clocked logic.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for fpga_spi_cs/sck/mosi (min 2).
- DATA_WIDTH, 8, payload width; frame length is 2*DATA_WIDTH bits.

Ports:
- fpga_clock_48mhz  in  1  system clock (single clock domain).
- reset_n  in  1  asynchronous active-low reset.
- fpga_spi_cs  in  1  SPI chip select, active low.
- fpga_spi_sck  in  1  SPI clock, mode 0.
- fpga_spi_mosi  in  1  MCU→FPGA data, MSB first.
- fpga_spi_miso  out  1  FPGA→MCU data, MSB first.
- rx_full  in  1  rx buffer holds a byte from the target.
- rx_data  in  DATA_WIDTH  rx buffer contents.
- tx_full  in  1  tx buffer occupied, awaiting target INPUT.
- tx_load  out  1  one-cycle pulse: write tx_data into tx buffer.
- tx_data  out  DATA_WIDTH  byte from MCU; valid when tx_load=1.
- rx_ack  out  1  one-cycle pulse: MCU consumed rx byte, clear rx_full.
- spi_busy  out  1  high while a frame is in progress (synced CS low).

Behaviour:
- Reset values: fpga_spi_miso=0, tx_load=0, tx_data=0, rx_ack=0, spi_busy=0, bit counter=0, state IDLE. Reset asserted mid-frame aborts the frame with no commit.
- Synchronisation: SYNC_STAGES flops per SPI input; edges are detected on the synchronised signals.
- Timing requirements on the MCU:
  - SCK high and low times ≥4 clocks each.
  - CS fall to first SCK rise ≥4 clocks.
  - Last SCK fall to CS rise ≥4 clocks.
- MOSI frame:
  - Byte 0 = flags. Bit1 = mcu_has_byte, bit0 = mcu_has_space, bits 7:2 ignored.
  - Byte 1 = data.
- MISO frame:
  - Byte 0 = flags. Bit1 = rx_full snapshot, bit0 = !tx_full snapshot, bits 7:2 = 0.
  - Byte 1 = rx_data snapshot when the rx_full snapshot is 1, else 0.
- State IDLE:
  - On synced CS falling edge: snapshot rx_full, tx_full and rx_data.
  - Load the 16-bit MISO shift register, drive its MSB on fpga_spi_miso.
  - Clear the bit counter, go to SHIFT.
- State SHIFT:
  - Synced SCK rise: shift MOSI into the rx shift register and increment the bit counter (saturating at 16).
  - Synced SCK fall: advance the MISO shift register.
  - Synced CS rise: go to COMMIT if the counter is 16, else go to IDLE without commit (aborted frame). Extra SCK pulses beyond 16 are ignored.
- State COMMIT (lasts 1 cycle, then IDLE):
  - tx_load=1 if mcu_has_byte && !tx_full snapshot; tx_data takes MOSI byte 1 and holds it until the next load.
  - rx_ack=1 if mcu_has_space && rx_full snapshot.
  - tx_load and rx_ack may pulse in the same cycle.
- Snapshot rule: changes to rx_full/tx_full during a frame do not affect that frame's flags or commit decisions. A byte arriving mid-frame is reported in the next frame.
- A CS falling edge while in COMMIT is not possible under the ≥4-clock gap; it must still be captured on the following IDLE cycle.
- Between frames fpga_spi_miso holds the last shifted value; the MCU must not sample it.
- spi_busy = synced CS low.

Test Plan:
- Idle frame:
  - Stimulus: rx_full=0, tx_full=0, MOSI flags=0x01.
  - Required: MISO = 0x01,0x00; no tx_load, no rx_ack.
- Null poll:
  - Stimulus: rx_full=1, rx_data=0xA8, MOSI flags=0x00, sent twice.
  - Required: MISO = 0x03,0xA8 both times; no rx_ack.
- Read then write:
  - Stimulus: flags=0x01 with rx_full=1 (0xA8).
  - Required: one rx_ack pulse.
  - Stimulus: then flags=0x03, data=0x73 with tx_full=0.
  - Required: tx_load with tx_data=0x73.
  - Stimulus: next frame data=0xE6 with tx_full=1.
  - Required: MISO flags bit0=0; no tx_load.
- Simultaneous commit:
  - Stimulus: rx_full=1 (0x42), tx_full=0, MOSI 0x03,0x12.
  - Required: tx_load and rx_ack in the same cycle; tx_data=0x12.
- Aborted frame:
  - Stimulus: CS rise after 11 bits.
  - Required: no pulses; the following full frame commits normally.
- Reset and mid-frame flag change:
  - Stimulus: reset_n low at bit 9.
  - Required: all outputs return to reset values; the following frame is correct.
  - Stimulus: rx_full rising during a frame.
  - Required: that frame reports flags bit1=0 and no rx_ack.
